// File: rtl/hazard_scoreboard.sv
// Forwarding and interlock unit for the 5-stage MIPS pipeline (ID side).
// Per-operand forwarding/hazard detection lives in hazard_operand, instantiated
// once per source operand. The top holds the one-entry mul/div scoreboard and
// the stall performance counter.

module hazard_operand #(
    parameter int AW = 5
) (
    input  logic [AW-1:0] src,
    input  logic          use_src,
    input  logic          branch,
    input  logic          ex_regwrite,
    input  logic          ex_memtoreg,
    input  logic [AW-1:0] ex_wreg,
    input  logic          me_regwrite,
    input  logic          me_memtoreg,
    input  logic [AW-1:0] me_wreg,
    input  logic          md_wb,
    input  logic [AW-1:0] md_wb_reg,
    input  logic          pend,
    input  logic [AW-1:0] pend_dst,
    output logic [1:0]    fwd,
    output logic          haz
);
    logic nz, m_ex, m_me, m_md, m_pend;

    // r0 is hardwired zero: it never matches, forwards or stalls
    assign nz     = |src;
    assign m_ex   = nz & ex_regwrite & (src == ex_wreg);
    assign m_me   = nz & me_regwrite & (src == me_wreg);
    assign m_md   = nz & md_wb & (src == md_wb_reg);
    assign m_pend = nz & pend & (src == pend_dst);

    // Source select, youngest producer first
    always_comb begin
        fwd = 2'b00;
        if (m_ex)      fwd = 2'b01;
        else if (m_me) fwd = 2'b10;
        else if (m_md) fwd = 2'b11;
    end

    // Load-use, branch-in-ID (EX result or ME load not yet available), and
    // RAW on an outstanding mul/div destination. Unused operands never stall.
    assign haz = use_src & ((m_ex & (ex_memtoreg | branch)) |
                            (branch & m_me & me_memtoreg) |
                            m_pend);
endmodule

module hazard_scoreboard #(
    parameter int AW     = 5,
    parameter int MD_LAT = 4,
    parameter int SCW    = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           id_valid,
    input  logic [AW-1:0]  id_rs,
    input  logic [AW-1:0]  id_rt,
    input  logic           id_use_rs,
    input  logic           id_use_rt,
    input  logic           id_branch,
    input  logic           id_md_issue,
    input  logic [AW-1:0]  id_md_dst,
    input  logic           flush,
    input  logic           ex_regwrite,
    input  logic           ex_memtoreg,
    input  logic [AW-1:0]  ex_wreg,
    input  logic           me_regwrite,
    input  logic           me_memtoreg,
    input  logic [AW-1:0]  me_wreg,
    output logic [1:0]     fwd_a,
    output logic [1:0]     fwd_b,
    output logic           stall,
    output logic           md_busy,
    output logic           md_wb,
    output logic [AW-1:0]  md_wb_reg,
    output logic [SCW-1:0] stall_cnt
);
    localparam int NUM_OPS = 2;   // operand 0 = rs, operand 1 = rt

    logic          busy;
    logic [3:0]    cnt;
    logic [AW-1:0] dst;
    logic          pend, act, issue_acc;

    logic [NUM_OPS-1:0][AW-1:0] src;
    logic [NUM_OPS-1:0]         use_v;
    logic [NUM_OPS-1:0][1:0]    fwd_v;
    logic [NUM_OPS-1:0]         haz;

    assign src   = {id_rt, id_rs};
    assign use_v = {id_use_rt, id_use_rs};

    assign md_wb     = busy & (cnt == 4'd0);
    assign md_wb_reg = dst;
    assign md_busy   = busy;
    assign pend      = busy & (cnt != 4'd0);

    for (genvar g = 0; g < NUM_OPS; g++) begin : g_op
        hazard_operand #(.AW(AW)) u_op (
            .src        (src[g]),
            .use_src    (use_v[g]),
            .branch     (id_branch),
            .ex_regwrite(ex_regwrite),
            .ex_memtoreg(ex_memtoreg),
            .ex_wreg    (ex_wreg),
            .me_regwrite(me_regwrite),
            .me_memtoreg(me_memtoreg),
            .me_wreg    (me_wreg),
            .md_wb      (md_wb),
            .md_wb_reg  (md_wb_reg),
            .pend       (pend),
            .pend_dst   (dst),
            .fwd        (fwd_v[g]),
            .haz        (haz[g])
        );
    end

    assign fwd_a = fwd_v[0];
    assign fwd_b = fwd_v[1];

    // A flushed or empty ID slot never stalls and never issues. A new issue
    // only collides with an op still counting down; the writeback cycle
    // itself is free, allowing back-to-back issue.
    assign act       = id_valid & ~flush;
    assign stall     = act & ((|haz) | (id_md_issue & pend));
    assign issue_acc = act & id_md_issue & ~stall;

    // Scoreboard entry: load on issue, otherwise count down and retire
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy <= 1'b0;
            cnt  <= 4'd0;
            dst  <= '0;
        end else if (issue_acc) begin
            busy <= 1'b1;
            cnt  <= 4'(MD_LAT - 1);
            dst  <= id_md_dst;
        end else begin
            if (pend)  cnt  <= cnt - 4'd1;
            if (md_wb) busy <= 1'b0;
        end
    end

    // Saturating stall-cycle counter
    always_ff @(posedge clk) begin
        if (!rst_n)
            stall_cnt <= '0;
        else if (stall && (stall_cnt != '1))
            stall_cnt <= stall_cnt + 1'b1;
    end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: each cycle the expected output
// vector is queued when stimulus is driven and popped for comparison at the
// falling edge. Small SCW so counter saturation is reachable.

module tb_hazard_scoreboard;
    localparam int AW     = 5;
    localparam int MD_LAT = 4;
    localparam int SCW    = 4;
    localparam int VW     = 7 + AW + SCW;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           id_valid, id_use_rs, id_use_rt, id_branch, id_md_issue, flush;
    logic [AW-1:0]  id_rs, id_rt, id_md_dst, ex_wreg, me_wreg;
    logic           ex_regwrite, ex_memtoreg, me_regwrite, me_memtoreg;
    logic [1:0]     fwd_a, fwd_b;
    logic           stall, md_busy, md_wb;
    logic [AW-1:0]  md_wb_reg;
    logic [SCW-1:0] stall_cnt;

    typedef struct {
        string          name;
        logic [VW-1:0]  v;
        logic           st;
    } exp_t;

    exp_t           q[$];
    exp_t           e;
    logic [VW-1:0]  obs;
    logic [SCW-1:0] exp_scnt;
    int             n_vec = 0;
    int             n_bad = 0;

    hazard_scoreboard #(.AW(AW), .MD_LAT(MD_LAT), .SCW(SCW)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_branch(id_branch),
        .id_md_issue(id_md_issue), .id_md_dst(id_md_dst), .flush(flush),
        .ex_regwrite(ex_regwrite), .ex_memtoreg(ex_memtoreg), .ex_wreg(ex_wreg),
        .me_regwrite(me_regwrite), .me_memtoreg(me_memtoreg), .me_wreg(me_wreg),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .stall(stall), .md_busy(md_busy),
        .md_wb(md_wb), .md_wb_reg(md_wb_reg), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    function automatic exp_t mk(string name, logic [1:0] fa, logic [1:0] fb,
                                logic st, logic bz, logic wb, logic [AW-1:0] wr);
        exp_t x;
        x.name = name;
        x.st   = st;
        x.v    = {fa, fb, st, bz, wb, (wb ? wr : {AW{1'b0}}), exp_scnt};
        return x;
    endfunction

    task automatic idle();
        id_valid = 0; id_rs = 0; id_rt = 0; id_use_rs = 0; id_use_rt = 0;
        id_branch = 0; id_md_issue = 0; id_md_dst = 0; flush = 0;
        ex_regwrite = 0; ex_memtoreg = 0; ex_wreg = 0;
        me_regwrite = 0; me_memtoreg = 0; me_wreg = 0;
    endtask

    // Advance one clock and update the reference stall counter
    task automatic tick(input logic st);
        @(posedge clk);
        if (!rst_n)
            exp_scnt = '0;
        else if (st && exp_scnt != {SCW{1'b1}})
            exp_scnt = exp_scnt + 1'b1;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 0; idle();
        tick(0); tick(0);
        rst_n = 1;
        for (int i = 0; i < 2; i++) begin
            idle();
            case (i)
                0: q.push_back(mk("rst_idle", 2'b00, 2'b00, 0, 0, 0, 0));
                default: begin
                    id_valid = 1; id_rs = 3; id_use_rs = 1; ex_wreg = 3; me_wreg = 3;
                    q.push_back(mk("rst_nowrite", 2'b00, 2'b00, 0, 0, 0, 0));
                end
            endcase
            @(negedge clk);
            e = q.pop_front(); n_vec++;
            obs = {fwd_a, fwd_b, stall, md_busy, md_wb, (md_wb ? md_wb_reg : {AW{1'b0}}), stall_cnt};
            if (obs !== e.v) begin
                n_bad++; $display("FAIL %s got=%h exp=%h", e.name, obs, e.v);
            end
            tick(e.st);
        end
    endtask

    task automatic test_load_use();
        for (int i = 0; i < 3; i++) begin
            idle();
            id_valid = 1; id_rs = 8; id_use_rs = 1;
            case (i)
                0: begin
                    ex_regwrite = 1; ex_memtoreg = 1; ex_wreg = 8;
                    q.push_back(mk("ld_use_ex", 2'b01, 2'b00, 1, 0, 0, 0));
                end
                1: begin
                    me_regwrite = 1; me_memtoreg = 1; me_wreg = 8;
                    q.push_back(mk("ld_use_me", 2'b10, 2'b00, 0, 0, 0, 0));
                end
                default: begin
                    id_rs = 3; id_rt = 8; id_use_rt = 0;
                    ex_regwrite = 1; ex_memtoreg = 1; ex_wreg = 8;
                    q.push_back(mk("ld_unused_rt", 2'b00, 2'b01, 0, 0, 0, 0));
                end
            endcase
            @(negedge clk);
            e = q.pop_front(); n_vec++;
            obs = {fwd_a, fwd_b, stall, md_busy, md_wb, (md_wb ? md_wb_reg : {AW{1'b0}}), stall_cnt};
            if (obs !== e.v) begin
                n_bad++; $display("FAIL %s got=%h exp=%h", e.name, obs, e.v);
            end
            tick(e.st);
        end
    endtask

    task automatic test_branch();
        for (int i = 0; i < 5; i++) begin
            idle();
            id_valid = 1; id_branch = 1; id_rs = 9; id_use_rs = 1;
            case (i)
                0: begin
                    ex_regwrite = 1; ex_wreg = 9;
                    q.push_back(mk("br_ex_alu", 2'b01, 2'b00, 1, 0, 0, 0));
                end
                1: begin
                    me_regwrite = 1; me_memtoreg = 1; me_wreg = 9;
                    q.push_back(mk("br_me_load", 2'b10, 2'b00, 1, 0, 0, 0));
                end
                2: begin
                    me_regwrite = 1; me_wreg = 9;
                    q.push_back(mk("br_me_alu", 2'b10, 2'b00, 0, 0, 0, 0));
                end
                3: begin
                    id_rs = 0; id_rt = 9; id_use_rt = 1; ex_regwrite = 1; ex_wreg = 9;
                    q.push_back(mk("br_rt_ex", 2'b00, 2'b01, 1, 0, 0, 0));
                end
                default: begin
                    id_branch = 0; id_rs = 0; id_rt = 9; id_use_rt = 1;
                    ex_regwrite = 1; ex_wreg = 9;
                    q.push_back(mk("nobr_rt_ex", 2'b00, 2'b01, 0, 0, 0, 0));
                end
            endcase
            @(negedge clk);
            e = q.pop_front(); n_vec++;
            obs = {fwd_a, fwd_b, stall, md_busy, md_wb, (md_wb ? md_wb_reg : {AW{1'b0}}), stall_cnt};
            if (obs !== e.v) begin
                n_bad++; $display("FAIL %s got=%h exp=%h", e.name, obs, e.v);
            end
            tick(e.st);
        end
    endtask

    task automatic test_md_raw();
        for (int i = 0; i < 6; i++) begin
            idle();
            if (i == 0) begin
                id_valid = 1; id_md_issue = 1; id_md_dst = 10;
                q.push_back(mk("raw_issue", 2'b00, 2'b00, 0, 0, 0, 0));
            end else if (i < MD_LAT) begin
                id_valid = 1; id_rs = 10; id_use_rs = 1;
                q.push_back(mk("raw_stall", 2'b00, 2'b00, 1, 1, 0, 0));
            end else if (i == MD_LAT) begin
                id_valid = 1; id_rs = 10; id_use_rs = 1;
                q.push_back(mk("raw_wb_fwd", 2'b11, 2'b00, 0, 1, 1, 10));
            end else begin
                q.push_back(mk("raw_done", 2'b00, 2'b00, 0, 0, 0, 0));
            end
            @(negedge clk);
            e = q.pop_front(); n_vec++;
            obs = {fwd_a, fwd_b, stall, md_busy, md_wb, (md_wb ? md_wb_reg : {AW{1'b0}}), stall_cnt};
            if (obs !== e.v) begin
                n_bad++; $display("FAIL %s got=%h exp=%h", e.name, obs, e.v);
            end
            tick(e.st);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 10; i++) begin
            idle();
            case (i)
                0: begin
                    id_valid = 1; id_md_issue = 1; id_md_dst = 10;
                    q.push_back(mk("b2b_issue1", 2'b00, 2'b00, 0, 0, 0, 0));
                end
                1: q.push_back(mk("b2b_gap", 2'b00, 2'b00, 0, 1, 0, 0));
                2, 3: begin
                    id_valid = 1; id_md_issue = 1; id_md_dst = 11;
                    q.push_back(mk("b2b_struct", 2'b00, 2'b00, 1, 1, 0, 0));
                end
                4: begin
                    id_valid = 1; id_md_issue = 1; id_md_dst = 11;
                    q.push_back(mk("b2b_accept", 2'b00, 2'b00, 0, 1, 1, 10));
                end
                8: q.push_back(mk("b2b_wb2", 2'b00, 2'b00, 0, 1, 1, 11));
                9: q.push_back(mk("b2b_done", 2'b00, 2'b00, 0, 0, 0, 0));
                default: q.push_back(mk("b2b_wait", 2'b00, 2'b00, 0, 1, 0, 0));
            endcase
            @(negedge clk);
            e = q.pop_front(); n_vec++;
            obs = {fwd_a, fwd_b, stall, md_busy, md_wb, (md_wb ? md_wb_reg : {AW{1'b0}}), stall_cnt};
            if (obs !== e.v) begin
                n_bad++; $display("FAIL %s got=%h exp=%h", e.name, obs, e.v);
            end
            tick(e.st);
        end
    endtask

    task automatic test_priority_zero();
        for (int i = 0; i < 11; i++) begin
            idle();
            case (i)
                0: begin
                    id_valid = 1; id_md_issue = 1; id_md_dst = 5;
                    q.push_back(mk("pri_issue", 2'b00, 2'b00, 0, 0, 0, 0));
                end
                1, 2, 3: q.push_back(mk("pri_wait", 2'b00, 2'b00, 0, 1, 0, 0));
                4: begin
                    id_valid = 1; id_rs = 5; id_rt = 5; id_use_rs = 1; id_use_rt = 1;
                    ex_regwrite = 1; ex_wreg = 5; me_regwrite = 1; me_wreg = 5;
                    q.push_back(mk("pri_ex_wins", 2'b01, 2'b01, 0, 1, 1, 5));
                end
                5: begin
                    id_valid = 1; id_md_issue = 1; id_md_dst = 0;
                    q.push_back(mk("zero_issue", 2'b00, 2'b00, 0, 0, 0, 0));
                end
                6, 7, 8: begin
                    id_valid = 1; id_rs = 0; id_use_rs = 1;
                    q.push_back(mk("zero_nopend", 2'b00, 2'b00, 0, 1, 0, 0));
                end
                9: begin
                    id_valid = 1; id_branch = 1; id_use_rs = 1; id_use_rt = 1;
                    ex_regwrite = 1; ex_memtoreg = 1; ex_wreg = 0;
                    me_regwrite = 1; me_memtoreg = 1; me_wreg = 0;
                    q.push_back(mk("zero_all", 2'b00, 2'b00, 0, 1, 1, 0));
                end
                default: q.push_back(mk("zero_done", 2'b00, 2'b00, 0, 0, 0, 0));
            endcase
            @(negedge clk);
            e = q.pop_front(); n_vec++;
            obs = {fwd_a, fwd_b, stall, md_busy, md_wb, (md_wb ? md_wb_reg : {AW{1'b0}}), stall_cnt};
            if (obs !== e.v) begin
                n_bad++; $display("FAIL %s got=%h exp=%h", e.name, obs, e.v);
            end
            tick(e.st);
        end
    endtask

    task automatic test_reset_flush();
        for (int i = 0; i < 14; i++) begin
            idle();
            case (i)
                0: begin
                    id_valid = 1; id_md_issue = 1; id_md_dst = 12;
                    q.push_back(mk("rf_issue", 2'b00, 2'b00, 0, 0, 0, 0));
                end
                1: begin
                    id_valid = 1; id_rs = 12; id_use_rs = 1;
                    q.push_back(mk("rf_pend", 2'b00, 2'b00, 1, 1, 0, 0));
                end
                2: begin
                    rst_n = 0; id_valid = 1; id_rs = 12; id_use_rs = 1;
                    q.push_back(mk("rf_in_rst", 2'b00, 2'b00, 1, 1, 0, 0));
                end
                3, 4: begin
                    rst_n = 1; id_valid = 1; id_rs = 12; id_use_rs = 1;
                    q.push_back(mk("rf_dropped", 2'b00, 2'b00, 0, 0, 0, 0));
                end
                5: begin
                    flush = 1; id_valid = 1; id_rs = 8; id_use_rs = 1;
                    ex_regwrite = 1; ex_memtoreg = 1; ex_wreg = 8;
                    q.push_back(mk("fl_ld_use", 2'b01, 2'b00, 0, 0, 0, 0));
                end
                6: begin
                    flush = 1; id_valid = 1; id_md_issue = 1; id_md_dst = 13;
                    q.push_back(mk("fl_issue", 2'b00, 2'b00, 0, 0, 0, 0));
                end
                7: q.push_back(mk("fl_no_busy", 2'b00, 2'b00, 0, 0, 0, 0));
                8: begin
                    id_valid = 1; id_md_issue = 1; id_md_dst = 14;
                    q.push_back(mk("fl_issue2", 2'b00, 2'b00, 0, 0, 0, 0));
                end
                9: begin
                    flush = 1; id_valid = 1; id_rs = 14; id_use_rs = 1;
                    q.push_back(mk("fl_pend", 2'b00, 2'b00, 0, 1, 0, 0));
                end
                12: q.push_back(mk("fl_wb_kept", 2'b00, 2'b00, 0, 1, 1, 14));
                13: q.push_back(mk("fl_done", 2'b00, 2'b00, 0, 0, 0, 0));
                default: q.push_back(mk("fl_wait", 2'b00, 2'b00, 0, 1, 0, 0));
            endcase
            @(negedge clk);
            e = q.pop_front(); n_vec++;
            obs = {fwd_a, fwd_b, stall, md_busy, md_wb, (md_wb ? md_wb_reg : {AW{1'b0}}), stall_cnt};
            if (obs !== e.v) begin
                n_bad++; $display("FAIL %s got=%h exp=%h", e.name, obs, e.v);
            end
            tick(e.st);
        end
    endtask

    task automatic test_saturate();
        for (int i = 0; i < 20; i++) begin
            idle();
            id_valid = 1; id_rs = 7; id_use_rs = 1;
            ex_regwrite = 1; ex_memtoreg = 1; ex_wreg = 7;
            q.push_back(mk("sat_hold", 2'b01, 2'b00, 1, 0, 0, 0));
            @(negedge clk);
            e = q.pop_front(); n_vec++;
            obs = {fwd_a, fwd_b, stall, md_busy, md_wb, (md_wb ? md_wb_reg : {AW{1'b0}}), stall_cnt};
            if (obs !== e.v) begin
                n_bad++; $display("FAIL %s got=%h exp=%h", e.name, obs, e.v);
            end
            tick(e.st);
        end
        idle();
    endtask

    initial begin
        exp_scnt = '0;
        test_reset();
        test_load_use();
        test_branch();
        test_md_raw();
        test_back_to_back();
        test_priority_zero();
        test_reset_flush();
        test_saturate();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
